// File: rtl/magnitude_stats.sv
// Windowed floor-mean / peak of a magnitude sample stream, with a per-sample
// hysteresis threshold alarm. Results are held until the consumer takes them.
//   state | meaning
//   ACCUM | collecting window samples, mag_ready high
//   HOLD  | result presented on avg_out/peak_out, input stalled
module magnitude_stats #(
  parameter int               WIDTH     = 8,
  parameter int               LOG2_WIN  = 3,
  parameter logic [WIDTH-1:0] THRESH_HI = 8'd180,
  parameter logic [WIDTH-1:0] THRESH_LO = 8'd120
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] mag_in,
  input  logic             mag_valid,
  output logic             mag_ready,
  output logic [WIDTH-1:0] avg_out,
  output logic [WIDTH-1:0] peak_out,
  output logic             stat_valid,
  input  logic             stat_ready,
  output logic             alarm,
  output logic             alarm_pulse
);

  localparam int                 SW   = WIDTH + LOG2_WIN;
  localparam logic [LOG2_WIN-1:0] LAST = '1;

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [SW-1:0]       r_sum;
  logic [WIDTH-1:0]    r_peak;
  logic [LOG2_WIN-1:0] r_count;
  logic                r_mag_ready;
  logic [WIDTH-1:0]    r_avg;
  logic [WIDTH-1:0]    r_peak_out;
  logic                r_stat_valid;
  logic                r_alarm;
  logic                r_alarm_pulse;

  logic                w_accept;
  logic                w_last;
  logic [SW-1:0]       w_sum_next;
  logic [WIDTH-1:0]    w_peak_next;

  always_comb begin
    w_accept    = mag_valid && r_mag_ready;
    w_last      = w_accept && (r_count == LAST);
    w_sum_next  = r_sum + {{LOG2_WIN{1'b0}}, mag_in};
    w_peak_next = (mag_in > r_peak) ? mag_in : r_peak;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ACCUM: if (w_last) w_state_next = HOLD;
      HOLD:  if (r_stat_valid && stat_ready) w_state_next = ACCUM;
      default: w_state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ACCUM;
      r_mag_ready <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_mag_ready <= (w_state_next == ACCUM);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum        <= '0;
      r_peak       <= '0;
      r_count      <= '0;
      r_avg        <= '0;
      r_peak_out   <= '0;
      r_stat_valid <= 1'b0;
    end else if (w_last) begin
      r_avg        <= w_sum_next[SW-1:LOG2_WIN];
      r_peak_out   <= w_peak_next;
      r_stat_valid <= 1'b1;
      r_sum        <= '0;
      r_peak       <= '0;
      r_count      <= '0;
    end else begin
      if (w_accept) begin
        r_sum   <= w_sum_next;
        r_peak  <= w_peak_next;
        r_count <= r_count + 1'b1;
      end
      if (r_state == HOLD && r_stat_valid && stat_ready)
        r_stat_valid <= 1'b0;
    end
  end

  // Alarm tracks every accepted sample, including a window's final one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alarm       <= 1'b0;
      r_alarm_pulse <= 1'b0;
    end else begin
      r_alarm_pulse <= 1'b0;
      if (w_accept) begin
        if (!r_alarm && mag_in >= THRESH_HI) begin
          r_alarm       <= 1'b1;
          r_alarm_pulse <= 1'b1;
        end else if (r_alarm && mag_in <= THRESH_LO) begin
          r_alarm <= 1'b0;
        end
      end
    end
  end

  assign mag_ready   = r_mag_ready;
  assign avg_out     = r_avg;
  assign peak_out    = r_peak_out;
  assign stat_valid  = r_stat_valid;
  assign alarm       = r_alarm;
  assign alarm_pulse = r_alarm_pulse;

endmodule

// File: tb/tb_magnitude_stats.sv
// Directed-vector bench for magnitude_stats: reset, windows, backpressure,
// saturation, hysteresis alarm and mid-window reset.
module tb_magnitude_stats;

  logic       clk;
  logic       rst_n;
  logic [7:0] mag_in;
  logic       mag_valid;
  logic       mag_ready;
  logic [7:0] avg_out;
  logic [7:0] peak_out;
  logic       stat_valid;
  logic       stat_ready;
  logic       alarm;
  logic       alarm_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  magnitude_stats dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mag_in      (mag_in),
    .mag_valid   (mag_valid),
    .mag_ready   (mag_ready),
    .avg_out     (avg_out),
    .peak_out    (peak_out),
    .stat_valid  (stat_valid),
    .stat_ready  (stat_ready),
    .alarm       (alarm),
    .alarm_pulse (alarm_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Presents v and returns at the negedge following the edge that accepted it.
  // mag_valid is left high so consecutive calls stream back-to-back.
  task automatic send(input logic [7:0] v);
    int n = 0;
    mag_in    = v;
    mag_valid = 1'b1;
    while (!mag_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_timeout", 32'd1, 32'd0);
    @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_ready"}, mag_ready, 0);
    chk({tag, "_avg"}, avg_out, 0);
    chk({tag, "_peak"}, peak_out, 0);
    chk({tag, "_svalid"}, stat_valid, 0);
    chk({tag, "_alarm"}, alarm, 0);
    chk({tag, "_pulse"}, alarm_pulse, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] hyst_v [5];
    logic       hyst_a [5];
    hyst_v = '{8'd100, 8'd185, 8'd150, 8'd119, 8'd130};
    hyst_a = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    // 1. Reset with toggling inputs
    rst_n = 1'b0; mag_in = 8'd0; mag_valid = 1'b0; stat_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mag_in = 8'(i * 70 + 3); mag_valid = ~mag_valid; stat_ready = ~stat_ready;
    end
    check_outputs_zero("rst");
    mag_valid = 1'b0; stat_ready = 1'b1;
    rst_n = 1'b1;
    chk("rst_ready_pre_edge", mag_ready, 0);
    @(negedge clk);
    chk("rst_ready_post_edge", mag_ready, 1);

    // 2. Window 10..80, sum 360 -> avg 45, peak 80
    for (int i = 1; i <= 8; i++) send(8'(i * 10));
    mag_valid = 1'b0;
    chk("win_svalid", stat_valid, 1);
    chk("win_avg", avg_out, 45);
    chk("win_peak", peak_out, 80);
    chk("win_ready", mag_ready, 0);
    @(negedge clk);
    chk("win_ready_back", mag_ready, 1);
    chk("win_svalid_drop", stat_valid, 0);

    // 3. Backpressure: window 0,2,..,14 -> avg 7, peak 14, then stall
    stat_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(8'(i * 2));
    mag_in = 8'd99; mag_valid = 1'b1;
    repeat (5) @(negedge clk);
    chk("bp_svalid", stat_valid, 1);
    chk("bp_avg", avg_out, 7);
    chk("bp_peak", peak_out, 14);
    chk("bp_ready", mag_ready, 0);
    stat_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(8'd4);
    mag_valid = 1'b0;
    chk("bp_next_avg", avg_out, 4);
    chk("bp_next_peak", peak_out, 4);
    chk("bp_next_svalid", stat_valid, 1);

    // 4. Saturation: eight 255s
    for (int i = 0; i < 8; i++) send(8'd255);
    mag_valid = 1'b0;
    chk("sat_avg", avg_out, 255);
    chk("sat_peak", peak_out, 255);
    chk("sat_alarm", alarm, 1);

    // 5. Hysteresis; alarm is 1 coming in, 100 clears it
    for (int i = 0; i < 5; i++) begin
      send(hyst_v[i]);
      chk($sformatf("hyst_alarm_%0d", hyst_v[i]), alarm, hyst_a[i]);
      chk($sformatf("hyst_pulse_%0d", hyst_v[i]), alarm_pulse, (i == 1) ? 1 : 0);
    end
    // Complete that window: sum 684 -> avg 85, peak 185
    for (int i = 0; i < 3; i++) send(8'd0);
    mag_valid = 1'b0;
    chk("hyst_win_avg", avg_out, 85);
    chk("hyst_win_peak", peak_out, 185);

    // 6. Mid-window reset after three 200s
    for (int i = 0; i < 3; i++) send(8'd200);
    mag_valid = 1'b0;
    chk("mid_alarm_set", alarm, 1);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("mid_rst");
    @(negedge clk);
    mag_valid = 1'b1; mag_in = 8'd77;
    @(negedge clk);
    mag_valid = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) send(8'd8);
    mag_valid = 1'b0;
    chk("mid_avg", avg_out, 8);
    chk("mid_peak", peak_out, 8);
    chk("mid_alarm", alarm, 0);
    chk("mid_svalid", stat_valid, 1);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
